spi_cmd_ctrl: RTL and testbench



---
 rtl/spi_cmd_pkg.sv | 14 +
 rtl/spi_cmd_ctrl_sync_2ff.sv | 24 ++
 rtl/spi_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types and command-byte field positions for the SPI command sequencer.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    RD_CAP = 2'd2
  } state_t;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_HI_BIT = 6;
  localparam int ADDR_W     = 6;

endpackage

// File: rtl/spi_cmd_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency 2 cycles; no flow control.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes two-byte SPI command frames into register strobes; reg_we 1 cycle after data byte, data_out 3 cycles after read command.
// No backpressure: a byte landing during read capture is held one cycle; SPI_CMD_ERR_EN enables address/frame error checking.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [5:0] reg_addr,
  output logic       reg_hi,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       cmd_err,
  input  logic       cmd_err_clr
);

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  state_t     state, state_nxt;
  logic       cs_sync, cs_prev, frame_end;
  logic       cap_wait, cap_wait_nxt;
  logic       pend, pend_nxt;
  logic       is_wr, is_wr_nxt;
  logic       bad, bad_nxt;
  logic       addr_bad, err_set;
  logic       byte_in_data;
  logic [7:0] data_out_nxt, reg_wdata_nxt;
  logic [5:0] reg_addr_nxt;
  logic       reg_hi_nxt, reg_we_nxt, reg_re_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_prev <= 1'b1;
    else        cs_prev <= cs_sync;
  end

  assign frame_end    = cs_sync & ~cs_prev;
  // A byte held over from RD_CAP counts as arriving in DATA.
  assign byte_in_data = byte_sync | pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (byte_sync) state_nxt = data_in[CMD_WR_BIT] ? DATA : RD_CAP;
      RD_CAP:  if (!cap_wait) state_nxt = DATA;
      DATA:    if (byte_in_data) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (frame_end) state_nxt = IDLE;
  end

  always_comb begin
    data_out_nxt  = data_out;
    reg_addr_nxt  = reg_addr;
    reg_hi_nxt    = reg_hi;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    is_wr_nxt     = is_wr;
    bad_nxt       = bad;
    cap_wait_nxt  = 1'b0;
    pend_nxt      = 1'b0;
    err_set       = 1'b0;
    unique case (state)
      IDLE: begin
        if (byte_sync) begin
          reg_addr_nxt = data_in[ADDR_W-1:0];
          reg_hi_nxt   = data_in[CMD_HI_BIT];
          is_wr_nxt    = data_in[CMD_WR_BIT];
          bad_nxt      = addr_bad;
          err_set      = addr_bad;
          reg_re_nxt   = ~data_in[CMD_WR_BIT] & ~addr_bad;
          cap_wait_nxt = ~data_in[CMD_WR_BIT];
        end
      end
      RD_CAP: begin
        pend_nxt = (pend | byte_sync) & ~frame_end;
        // First RD_CAP cycle is the reg_re cycle; rdata is valid on the second.
        if (!cap_wait) data_out_nxt = bad ? 8'h00 : reg_rdata;
      end
      DATA: begin
        if (byte_in_data) begin
          if (is_wr && !bad) begin
            reg_wdata_nxt = data_in;
            reg_we_nxt    = 1'b1;
          end
        end else if (frame_end) begin
          err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= 8'h00;
      reg_addr  <= 6'd0;
      reg_hi    <= 1'b0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      is_wr     <= 1'b0;
      bad       <= 1'b0;
      cap_wait  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      data_out  <= data_out_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_hi    <= reg_hi_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= reg_re_nxt;
      is_wr     <= is_wr_nxt;
      bad       <= bad_nxt;
      cap_wait  <= cap_wait_nxt;
      pend      <= pend_nxt;
    end
  end

`ifdef SPI_CMD_ERR_EN
  assign addr_bad = ({1'b0, data_in[ADDR_W-1:0]} >= NUM_REGS_W);

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cmd_err <= 1'b0;
    else if (err_set)     cmd_err <= 1'b1;
    else if (cmd_err_clr) cmd_err <= 1'b0;
  end
`else
  logic unused_err_cfg;
  assign addr_bad       = 1'b0;
  assign cmd_err        = 1'b0;
  assign unused_err_cfg = cmd_err_clr ^ err_set ^ NUM_REGS_W[0];
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: frame-level model builds an expected per-cycle timeline, compared every cycle.
module tb_spi_cmd_ctrl;

  localparam int NUM_REGS = 16;
  localparam int MAXC     = 4096;
`ifdef SPI_CMD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, cs_n, byte_sync, cmd_err_clr;
  logic [7:0] data_in, data_out, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic [5:0] reg_addr;
  logic       reg_hi, reg_we, reg_re, cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.NUM_REGS(NUM_REGS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .byte_sync   (byte_sync),
    .data_in     (data_in),
    .data_out    (data_out),
    .reg_addr    (reg_addr),
    .reg_hi      (reg_hi),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .cmd_err     (cmd_err),
    .cmd_err_clr (cmd_err_clr)
  );

  function automatic logic [7:0] rf_val(input logic hi, input logic [5:0] a);
    if (hi && a == 6'd2) return 8'hA7;
    return {1'b0, hi, a} ^ 8'h5A;
  endfunction

  always @(posedge clk) if (reg_re) reg_rdata <= rf_val(reg_hi, reg_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected timeline, indexed by the cycle in which the registered output is visible.
  bit         e_we[MAXC], e_re[MAXC], c_addr[MAXC], c_dout[MAXC], c_wd[MAXC], c_errs[MAXC], c_errc[MAXC];
  logic [6:0] v_addr[MAXC];
  logic [7:0] v_dout[MAXC], v_wd[MAXC];

  int         nbytes = 0, cmd_e = 0, pend_f = -1, err_at = -1, bs_cyc = 0;
  logic [7:0] cmd_m = 8'h00;
  bit         bad_m = 1'b0;

  function automatic void model_byte(input logic [7:0] b, input int e);
    if (pend_f >= 0 && e > pend_f) begin
      nbytes = 0;
      pend_f = -1;
    end
    if (nbytes == 0) begin
      cmd_m  = b;
      cmd_e  = e;
      nbytes = 1;
      bad_m  = ERR_EN && (int'(b[5:0]) >= NUM_REGS);
      c_addr[e] = 1'b1;
      v_addr[e] = b[6:0];
      if (bad_m) c_errs[e] = 1'b1;
      if (!b[7]) begin
        if (!bad_m) e_re[e] = 1'b1;
        c_dout[e+2] = 1'b1;
        v_dout[e+2] = bad_m ? 8'h00 : rf_val(b[6], b[5:0]);
      end
    end else begin
      nbytes = 0;
      err_at = -1;
      if (cmd_m[7] && !bad_m) begin
        e_we[e] = 1'b1;
        c_wd[e] = 1'b1;
        v_wd[e] = b;
      end
    end
  endfunction

  int         we_cnt = 0, re_cnt = 0, we_cyc = 0, dout_cyc = 0;
  logic [6:0] cur_a = 7'd0;
  logic [7:0] cur_d = 8'h00, cur_w = 8'h00, last_dout = 8'h00;
  bit         cur_e = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        cur_a = 7'd0; cur_d = 8'h00; cur_w = 8'h00; cur_e = 1'b0;
      end else if (cyc < MAXC) begin
        if (c_addr[cyc]) cur_a = v_addr[cyc];
        if (c_dout[cyc]) cur_d = v_dout[cyc];
        if (c_wd[cyc])   cur_w = v_wd[cyc];
        if (c_errs[cyc] || cyc == err_at) cur_e = 1'b1;
        else if (c_errc[cyc])             cur_e = 1'b0;
      end
      if (cyc < MAXC) begin
        chk("reg_we",    32'(reg_we), 32'(e_we[cyc]));
        chk("reg_re",    32'(reg_re), 32'(e_re[cyc] && rst_n));
        chk("reg_addr",  32'({reg_hi, reg_addr}), 32'(cur_a));
        chk("data_out",  32'(data_out), 32'(cur_d));
        chk("reg_wdata", 32'(reg_wdata), 32'(cur_w));
        chk("cmd_err",   32'(cmd_err), 32'(cur_e));
      end
      if (reg_we === 1'b1) begin we_cnt++; we_cyc = cyc; end
      if (reg_re === 1'b1) re_cnt++;
      if (data_out !== last_dout) begin dout_cyc = cyc; last_dout = data_out; end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b, cyc + 1);
    bs_cyc    = cyc;
    byte_sync = 1'b1;
    data_in   = b;
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic cs_fall();
    cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_rise();
    cs_n   = 1'b1;
    pend_f = cyc + 3;
    if (nbytes == 1 && ERR_EN && (cmd_m[7] || cyc + 3 >= cmd_e + 3)) err_at = cyc + 3;
    @(negedge clk);
  endtask

  task automatic err_clear();
    cmd_err_clr = 1'b1;
    c_errc[cyc+1] = 1'b1;
    @(negedge clk);
    cmd_err_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n  = 1'b0;
    nbytes = 0;
    pend_f = -1;
    err_at = -1;
    for (int i = cyc; i < cyc + 10 && i < MAXC; i++) begin
      e_we[i] = 1'b0; e_re[i] = 1'b0; c_addr[i] = 1'b0; c_dout[i] = 1'b0;
      c_wd[i] = 1'b0; c_errs[i] = 1'b0; c_errc[i] = 1'b0;
    end
    idle(2);
    chk("rst_data_out",  32'(data_out), 32'h00);
    chk("rst_reg_addr",  32'({reg_hi, reg_addr}), 32'h00);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_strobes",   32'({reg_we, reg_re, cmd_err}), 32'h0);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int we0;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00; cmd_err_clr = 1'b0;
    idle(3);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_outputs",  32'({reg_hi, reg_addr, reg_wdata, reg_we, reg_re, cmd_err}), 32'h0);
    rst_n = 1'b1;
    idle(3);

    // Plain write frame.
    cs_fall(); idle(2);
    send(8'h85); idle(1); send(8'h3C); idle(3);
    cs_rise(); idle(6);
    chk("wr_we_count", 32'(we_cnt), 32'd1);
    chk("wr_latency",  32'(we_cyc - bs_cyc), 32'd1);
    chk("wr_wdata",    32'(reg_wdata), 32'h3C);
    chk("wr_addr",     32'({reg_hi, reg_addr}), 32'h05);

    // Read frame; value must survive a following write frame.
    cs_fall(); idle(2);
    send(8'h42); we0 = bs_cyc; idle(4); send(8'h00); idle(2);
    cs_rise(); idle(6);
    chk("rd_data_out", 32'(data_out), 32'hA7);
    chk("rd_latency",  32'(dout_cyc - we0), 32'd3);
    chk("rd_addr",     32'({reg_hi, reg_addr}), 32'h42);
    chk("rd_re_count", 32'(re_cnt), 32'd1);
    cs_fall(); idle(2);
    send(8'h83); idle(1); send(8'h55); idle(2);
    cs_rise(); idle(6);
    chk("rd_held", 32'(data_out), 32'hA7);

    // Dummy byte arrives during capture and must not be lost.
    cs_fall(); idle(2);
    send(8'h03); send(8'h00); idle(2);
    send(8'h87); send(8'h99); idle(3);
    cs_rise(); idle(6);
    chk("held_rdata", 32'(data_out), 32'h59);
    chk("held_wdata", 32'(reg_wdata), 32'h99);

    // Partial frame, then a normal one.
    we0 = we_cnt;
    cs_fall(); idle(2);
    send(8'h81); idle(3);
    cs_rise(); idle(6);
    chk("partial_no_we", 32'(we_cnt), 32'(we0));
`ifdef SPI_CMD_ERR_EN
    chk("partial_err", 32'(cmd_err), 32'd1);
`endif
    err_clear(); idle(2);
    cs_fall(); idle(2);
    send(8'h81); idle(1); send(8'h11); idle(2);
    cs_rise(); idle(6);
    chk("after_partial_wdata", 32'(reg_wdata), 32'h11);
    chk("after_partial_we",    32'(we_cnt), 32'(we0 + 1));

    // Data byte coincides with frame end: still written.
    cs_fall(); idle(2);
    send(8'h84); idle(2);
    cs_rise(); idle(1); send(8'h66); idle(6);
    chk("edge_wdata", 32'(reg_wdata), 32'h66);

    // Reset in the middle of a write frame.
    cs_fall(); idle(2);
    send(8'h8A); idle(2);
    pulse_reset();
    cs_rise(); idle(6);
    cs_fall(); idle(2);
    send(8'h8A); idle(1); send(8'h77); idle(2);
    cs_rise(); idle(6);
    chk("post_reset_wdata", 32'(reg_wdata), 32'h77);
    chk("post_reset_addr",  32'({reg_hi, reg_addr}), 32'h0A);

    // Address beyond NUM_REGS.
    we0 = we_cnt;
    cs_fall(); idle(2);
    send(8'h9F); idle(1); send(8'hFF); idle(2);
`ifdef SPI_CMD_ERR_EN
    chk("bad_addr_err",   32'(cmd_err), 32'd1);
    chk("bad_addr_no_we", 32'(we_cnt), 32'(we0));
    err_clear(); idle(1);
    chk("err_cleared", 32'(cmd_err), 32'd0);
`else
    chk("addr_1f_we",    32'(we_cnt), 32'(we0 + 1));
    chk("addr_1f_addr",  32'({reg_hi, reg_addr}), 32'h1F);
    chk("addr_1f_wdata", 32'(reg_wdata), 32'hFF);
    err_clear(); idle(1);
    chk("err_tied_low", 32'(cmd_err), 32'd0);
`endif
    cs_rise(); idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
